// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning block.
package btn_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // Number of button channels handled by the block.
    localparam int NUM_BTN = 4;

    // Channel index of each button in the btn_* vectors.
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;

endpackage : btn_pkg

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, press pulse and
// auto-repeat pulse generation. All outputs are registered.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16,
    parameter int CNT_W         = 8
) (
    input  logic clk_d,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic press,
    output logic rpt
);

    localparam logic [CNT_W-1:0] DB_C     = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);
    // A zero first-repeat delay turns auto-repeat off entirely.
    localparam bit               REPEAT_EN = (REPEAT_DELAY != 0);

    logic             sync1_r;
    logic             sync_r;
    db_state_t        state_r;
    db_state_t        state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] rcnt_r;
    logic [CNT_W-1:0] rcnt_s;
    logic [CNT_W-1:0] rcnt_inc_s;
    logic             first_r;
    logic             first_s;
    logic             clean_r;
    logic             clean_s;
    logic             press_r;
    logic             press_s;
    logic             rpt_r;
    logic             rpt_s;

    // Two-flop synchroniser bringing the raw button into the clk_d domain.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync_r  <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync_r  <= sync1_r;
        end
    end

    // Next-state, counter and output decode for the debounce FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        rcnt_s     = rcnt_r;
        first_s    = first_r;
        press_s    = 1'b0;
        rpt_s      = 1'b0;
        rcnt_inc_s = rcnt_r + ONE_C;
        case (state_r)
            IDLE: begin
                if (sync_r) begin
                    state_s = PRESS_WAIT;
                    cnt_s   = ONE_C;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!sync_r) begin
                    // Bounce before the press was accepted.
                    state_s = IDLE;
                end else if (cnt_r == DB_C) begin
                    state_s = HELD;
                    press_s = 1'b1;
                    rpt_s   = 1'b1;
                    rcnt_s  = ZERO_C;
                    first_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + ONE_C;
                end
            end
            HELD: begin
                if (!sync_r) begin
                    // rcnt stays frozen so a rejected release glitch keeps the cadence.
                    state_s = RELEASE_WAIT;
                    cnt_s   = ONE_C;
                end else if (REPEAT_EN) begin
                    if ((first_r && (rcnt_inc_s == DELAY_C)) ||
                        (!first_r && (rcnt_inc_s == PERIOD_C))) begin
                        rpt_s   = 1'b1;
                        rcnt_s  = ZERO_C;
                        first_s = 1'b0;
                    end else begin
                        rcnt_s = rcnt_inc_s;
                    end
                end else begin
                    rcnt_s = rcnt_r;
                end
            end
            RELEASE_WAIT: begin
                if (sync_r) begin
                    // Release glitch: resume holding without a new press.
                    state_s = HELD;
                end else if (cnt_r == DB_C) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + ONE_C;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = ZERO_C;
                rcnt_s  = ZERO_C;
                first_s = 1'b0;
            end
        endcase
        clean_s = (state_s == HELD) || (state_s == RELEASE_WAIT);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= ZERO_C;
            rcnt_r  <= ZERO_C;
            first_r <= 1'b0;
            clean_r <= 1'b0;
            press_r <= 1'b0;
            rpt_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rcnt_r  <= rcnt_s;
            first_r <= first_s;
            clean_r <= clean_s;
            press_r <= press_s;
            rpt_r   <= rpt_s;
        end
    end

    assign clean = clean_r;
    assign press = press_r;
    assign rpt   = rpt_r;

endmodule : btn_debounce_ch

// File: rtl/btn_debounce.sv
// Four independent push-button conditioning channels feeding the direction
// stage (btn_clean) and the maze step logic (btn_press, btn_repeat).
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16,
    parameter int CNT_W         = 8
) (
    input  logic               clk_d,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_clean,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk_d (clk_d),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .clean (btn_clean[i]),
            .press (btn_press[i]),
            .rpt   (btn_repeat[i])
        );
    end

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus randomized button activity,
// checked cycle by cycle against a run-length reference model. A second
// instance runs with auto-repeat disabled on the same stimulus.
module tb_btn_debounce;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic       clk_d;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] clean;
    logic [3:0] press;
    logic [3:0] rpt;
    logic [3:0] nr_clean;
    logic [3:0] nr_press;
    logic [3:0] nr_rpt;

    int n_checks;
    int n_errors;

    btn_debounce #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)) dut (
        .clk_d      (clk_d),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_clean  (clean),
        .btn_press  (press),
        .btn_repeat (rpt)
    );

    btn_debounce #(.DB_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP), .CNT_W(8)) dut_nr (
        .clk_d      (clk_d),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_clean  (nr_clean),
        .btn_press  (nr_press),
        .btn_repeat (nr_rpt)
    );

    initial clk_d = 1'b0;
    always #5 clk_d = ~clk_d;

    // ---------------- reference model ----------------
    // Per channel: the synchronised samples the debouncer sees, the last DB+1
    // of them, the accepted level and how many held cycles have elapsed.
    localparam logic [DB:0] ALL1 = '1;
    logic [3:0]  m_s1;
    logic [3:0]  m_s;
    logic [DB:0] hist [4];
    logic [3:0]  lvl;
    int          held_n [4];
    logic [3:0]  exp_press;
    logic [3:0]  exp_rpt;
    logic [3:0]  exp_rpt_nr;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic is_tick(input int n, input int d, input int p);
        return (d != 0) && (n >= d) && (((n - d) % p) == 0);
    endfunction

    task automatic model_clear();
        m_s1       = '0;
        m_s        = '0;
        lvl        = '0;
        exp_press  = '0;
        exp_rpt    = '0;
        exp_rpt_nr = '0;
        for (int c = 0; c < 4; c++) begin
            hist[c]   = '0;
            held_n[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic s_seen;
        exp_press  = '0;
        exp_rpt    = '0;
        exp_rpt_nr = '0;
        if (rst) begin
            model_clear();
        end else begin
            for (int c = 0; c < 4; c++) begin
                s_seen  = m_s[c];
                m_s[c]  = m_s1[c];
                m_s1[c] = btn_raw[c];
                hist[c] = {hist[c][DB-1:0], s_seen};
                if (!lvl[c] && (hist[c] == ALL1)) begin
                    lvl[c]        = 1'b1;
                    held_n[c]     = 0;
                    exp_press[c]  = 1'b1;
                    exp_rpt[c]    = 1'b1;
                    exp_rpt_nr[c] = 1'b1;
                end else if (lvl[c] && (hist[c] == '0)) begin
                    lvl[c] = 1'b0;
                end else if (lvl[c] && hist[c][0] && hist[c][1]) begin
                    held_n[c]++;
                    exp_rpt[c]    = is_tick(held_n[c], RD, RP);
                    exp_rpt_nr[c] = is_tick(held_n[c], 0, RP);
                end
            end
        end
    endtask

    task automatic compare_all();
        check("clean", int'(clean), int'(lvl));
        check("press", int'(press), int'(exp_press));
        check("repeat", int'(rpt), int'(exp_rpt));
        check("nr_clean", int'(nr_clean), int'(lvl));
        check("nr_press", int'(nr_press), int'(exp_press));
        check("nr_repeat", int'(nr_rpt), int'(exp_rpt_nr));
    endtask

    // One clock edge: advance the model, then sample outputs 1 time unit later.
    task automatic step();
        @(posedge clk_d);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Raise rst between edges and confirm every output drops at once.
    task automatic async_reset_check(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        check({tag, "_clean"}, int'(clean | nr_clean), 0);
        check({tag, "_press"}, int'(press | nr_press), 0);
        check({tag, "_rpt"}, int'(rpt | nr_rpt), 0);
    endtask

    initial begin
        int acc;
        int cnt_a;
        int cnt_b;
        int first_at;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        btn_raw  = 4'b0000;
        model_clear();

        // Reset state
        #2;
        check("reset_clean", int'(clean), 0);
        check("reset_press", int'(press), 0);
        check("reset_rpt", int'(rpt), 0);
        steps(2);
        rst = 1'b0;
        steps(3);

        // 1. Clean press on channel 0
        btn_raw = 4'b0001;
        steps(6);
        check("t1_clean_early", int'(clean), 0);
        step();
        check("t1_clean", int'(clean), 1);
        check("t1_press", int'(press), 1);
        check("t1_rpt0", int'(rpt), 1);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            cnt_a += int'(rpt[0]);
            cnt_b += int'(press[0]);
            if (i == 8) check("t1_rpt_first", int'(rpt), 1);
        end
        check("t1_rpt_count", cnt_a, 5);
        check("t1_press_count", cnt_b, 0);
        btn_raw = 4'b0000;
        steps(12);

        // 2. Press bounce on channel 2
        btn_raw = 4'b0100;
        acc = 0;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) btn_raw = 4'b0000;
            step();
            acc |= int'(clean | press | rpt);
        end
        check("t2_quiet", acc, 0);
        btn_raw = 4'b0100;
        steps(6);
        check("t2_again_early", int'(clean), 0);
        step();
        check("t2_again_press", int'(press), 4);
        btn_raw = 4'b0000;
        steps(12);

        // 3. Release glitch then real release on channel 1
        btn_raw = 4'b0010;
        steps(7);
        check("t3_press", int'(press), 2);
        steps(5);
        btn_raw  = 4'b0000;
        acc      = 0;
        cnt_b    = 0;
        first_at = -1;
        for (int i = 0; i < 22; i++) begin
            if (i == 2) btn_raw = 4'b0010;
            step();
            if (clean[1] == 1'b0) acc++;
            cnt_b += int'(press[1]);
            if (rpt[1] && first_at < 0) first_at = i + 1;
        end
        check("t3_glitch_clean", acc, 0);
        check("t3_glitch_press", cnt_b, 0);
        check("t3_rcnt_kept", first_at, 6);
        btn_raw = 4'b0000;
        steps(6);
        check("t3_rel_early", int'(clean), 2);
        step();
        check("t3_rel", int'(clean), 0);
        steps(6);

        // 4. Simultaneous channels 0 and 3
        btn_raw = 4'b1001;
        steps(7);
        check("t4_clean", int'(clean), 9);
        check("t4_press", int'(press), 9);
        step();
        check("t4_press_once", int'(press), 0);
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if ((rpt & 4'b1001) != 4'b0000 && (rpt & 4'b1001) != 4'b1001) acc++;
        end
        check("t4_rpt_coincident", acc, 0);

        // 5. Reset mid-HELD with channel 3 held
        btn_raw = 4'b1000;
        steps(10);
        async_reset_check("t5_async");
        steps(2);
        rst = 1'b0;
        steps(6);
        check("t5_early", int'(clean), 0);
        step();
        check("t5_clean", int'(clean), 8);
        check("t5_press", int'(press), 8);
        btn_raw = 4'b0000;
        steps(12);

        // 6. Auto-repeat disabled instance, channel 0 held for 100 cycles
        btn_raw = 4'b0001;
        cnt_a   = 0;
        cnt_b   = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cnt_a += int'(nr_rpt[0]);
            cnt_b += int'(nr_press[0]);
            if (nr_press[0]) check("t6_coincident", int'(nr_rpt[0]), 1);
        end
        check("t6_rpt_count", cnt_a, 1);
        check("t6_press_count", cnt_b, 1);
        btn_raw = 4'b0000;
        steps(12);

        // Randomized activity: per-channel bouncy or stable phases, rare resets.
        begin
            logic [3:0] mode;
            mode = 4'b0000;
            for (int i = 0; i < 1500; i++) begin
                if (i % 40 == 0) mode = 4'($urandom_range(0, 15));
                for (int c = 0; c < 4; c++) begin
                    if (mode[c]) begin
                        if ($urandom_range(0, 2) == 0) btn_raw[c] = ~btn_raw[c];
                    end else begin
                        if ($urandom_range(0, 29) == 0) btn_raw[c] = ~btn_raw[c];
                    end
                end
                if ($urandom_range(0, 299) == 0) begin
                    async_reset_check("rand_async");
                    step();
                    rst = 1'b0;
                end else begin
                    step();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_btn_debounce
